// File: rtl/bf_run_controller.sv
// Loads an ASCII brainfuck program from a UART byte stream, zeroes data memory, then runs the core until core_pc reaches the end of the program.
// Bytes are accepted in the cycle they arrive; each program write follows one cycle later. Acceptance only happens in LOAD, so any backpressure comes from the state.
module bf_run_controller #(
  parameter int PROG_ADDR_WIDTH = 10,
  parameter int PROG_DATA_WIDTH = 3,
  parameter int MEM_ADDR_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic                       rx_ack,
  output logic                       prog_wr_en,
  output logic [PROG_ADDR_WIDTH-1:0] prog_wr_addr,
  output logic [PROG_DATA_WIDTH-1:0] prog_wr_data,
  output logic                       mem_clr_wr_en,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_clr_addr,
  input  logic [PROG_ADDR_WIDTH-1:0] core_pc,
  output logic                       core_rst,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [2:0]                 debug_state
);

  localparam logic [PROG_DATA_WIDTH-1:0] I_RIGHT = PROG_DATA_WIDTH'(0);
  localparam logic [PROG_DATA_WIDTH-1:0] I_LEFT  = PROG_DATA_WIDTH'(1);
  localparam logic [PROG_DATA_WIDTH-1:0] I_PLUS  = PROG_DATA_WIDTH'(2);
  localparam logic [PROG_DATA_WIDTH-1:0] I_MINUS = PROG_DATA_WIDTH'(3);
  localparam logic [PROG_DATA_WIDTH-1:0] I_OUT   = PROG_DATA_WIDTH'(4);
  localparam logic [PROG_DATA_WIDTH-1:0] I_IN    = PROG_DATA_WIDTH'(5);
  localparam logic [PROG_DATA_WIDTH-1:0] I_JZ    = PROG_DATA_WIDTH'(6);
  localparam logic [PROG_DATA_WIDTH-1:0] I_JNZ   = PROG_DATA_WIDTH'(7);

  // The top program address is never written: the core treats it as the halt marker.
  localparam logic [PROG_ADDR_WIDTH-1:0] PROG_MAX = {PROG_ADDR_WIDTH{1'b1}};
  localparam logic [MEM_ADDR_WIDTH-1:0]  CLR_MAX  = {MEM_ADDR_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CLEAR = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t                     state;
  logic [PROG_ADDR_WIDTH-1:0] prog_len;
  logic [7:0]                 depth;
  logic [MEM_ADDR_WIDTH-1:0]  clr_cnt;
  logic                       wr_pend;
  logic [PROG_ADDR_WIDTH-1:0] wr_addr;
  logic [PROG_DATA_WIDTH-1:0] wr_data;

  logic                       is_instr;
  logic [PROG_DATA_WIDTH-1:0] code;
  logic                       is_open;
  logic                       is_close;
  logic                       is_term;

  always_comb begin
    is_instr = 1'b1;
    code     = I_RIGHT;
    case (rx_data)
      8'h3E:   code = I_RIGHT;
      8'h3C:   code = I_LEFT;
      8'h2B:   code = I_PLUS;
      8'h2D:   code = I_MINUS;
      8'h2E:   code = I_OUT;
      8'h2C:   code = I_IN;
      8'h5B:   code = I_JZ;
      8'h5D:   code = I_JNZ;
      default: is_instr = 1'b0;
    endcase
  end

  assign is_open  = (rx_data == 8'h5B);
  assign is_close = (rx_data == 8'h5D);
  assign is_term  = (rx_data == 8'h00);

  // Abort wins over an arriving byte, so a byte is never acked without being processed.
  assign rx_ack        = (state == S_LOAD) && rx_valid && !abort;
  assign prog_wr_en    = wr_pend && !abort;
  assign prog_wr_addr  = wr_addr;
  assign prog_wr_data  = wr_data;
  assign mem_clr_wr_en = (state == S_CLEAR) && !abort;
  assign mem_clr_addr  = clr_cnt;
  assign core_rst      = (state != S_RUN);
  assign busy          = (state == S_LOAD) || (state == S_CLEAR) || (state == S_RUN);
  assign done          = (state == S_DONE);
  assign err           = (state == S_ERROR);
  assign debug_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      prog_len <= '0;
      depth    <= '0;
      clr_cnt  <= '0;
      wr_pend  <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_pend <= 1'b0;
      if (abort) begin
        state   <= S_IDLE;
        clr_cnt <= '0;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
              state    <= S_LOAD;
              prog_len <= '0;
              depth    <= '0;
              wr_addr  <= '0;
            end
          end
          S_LOAD: begin
            if (rx_valid) begin
              if (is_term) begin
                if (depth != 8'd0)
                  state <= S_ERROR;
                else if (prog_len == '0)
                  state <= S_DONE;
                else begin
                  state   <= S_CLEAR;
                  clr_cnt <= '0;
                end
              end else if (is_instr) begin
                if ((prog_len == PROG_MAX) || (is_open && depth == 8'hFF) ||
                    (is_close && depth == 8'd0)) begin
                  state <= S_ERROR;
                end else begin
                  wr_pend  <= 1'b1;
                  wr_addr  <= prog_len;
                  wr_data  <= code;
                  prog_len <= prog_len + PROG_ADDR_WIDTH'(1);
                  if (is_open)
                    depth <= depth + 8'd1;
                  else if (is_close)
                    depth <= depth - 8'd1;
                end
              end
            end
          end
          S_CLEAR: begin
            clr_cnt <= clr_cnt + MEM_ADDR_WIDTH'(1);
            if (clr_cnt == CLR_MAX)
              state <= S_RUN;
          end
          S_RUN: begin
            if (core_pc == prog_len)
              state <= S_DONE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/bf_run_controller.md
BF_RUN_CONTROLLER -- requirements
Module: bf_run_controller

Interface
REQ-001 SHALL have parameter PROG_ADDR_WIDTH, default 10, program memory address width.
REQ-002 SHALL have parameter PROG_DATA_WIDTH, default 3, encoded instruction width.
REQ-003 SHALL have parameter MEM_ADDR_WIDTH, default 8, data memory address width.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse; begin a load from IDLE, DONE or ERROR.
REQ-007 SHALL have port abort  in  1  return to IDLE from any state.
REQ-008 SHALL have port rx_valid  in  1  UART byte available.
REQ-009 SHALL have port rx_data  in  8  UART byte, ASCII source.
REQ-010 SHALL have port rx_ack  out  1  byte consumed this cycle.
REQ-011 SHALL have ports prog_wr_en (out, 1), prog_wr_addr (out, PROG_ADDR_WIDTH) and prog_wr_data (out, PROG_DATA_WIDTH) for the program memory write port.
REQ-012 SHALL have ports mem_clr_wr_en (out, 1) and mem_clr_addr (out, MEM_ADDR_WIDTH) for the data memory zero-write port.
REQ-013 SHALL have port core_pc  in  PROG_ADDR_WIDTH  current core program counter.
REQ-014 SHALL have port core_rst  out  1  active-high core reset; high in every state except RUN.
REQ-015 SHALL have ports busy (out, 1), done (out, 1), err (out, 1) and debug_state (out, 3).

Function
REQ-016 SHALL implement states IDLE=0, LOAD=1, CLEAR=2, RUN=3, DONE=4, ERROR=5 and drive debug_state with the current state.
REQ-017 IDLE/DONE/ERROR: start SHALL go to LOAD, clear prog_len, bracket depth and write address; start in LOAD/CLEAR/RUN SHALL be ignored.
REQ-018 LOAD: rx_ack SHALL equal rx_valid (combinational); every acked byte SHALL be processed exactly once.
REQ-019 Bytes > < + - . , [ ] SHALL be translated to the matching I_* code of brainfuck_constants; prog_wr_en SHALL pulse one cycle after acceptance, at address prog_len, which SHALL then increment.
REQ-020 All other bytes except terminator 0x00 SHALL be acked and discarded with no write.
REQ-021 Bracket depth (8-bit) SHALL increment on '[' and decrement on ']'; ']' at depth 0 or '[' at depth 255 SHALL go to ERROR with no write.
REQ-022 An instruction byte arriving when prog_len = 2^PROG_ADDR_WIDTH - 1 SHALL go to ERROR with no write; the last address stays reserved as the halt marker.
REQ-023 Terminator: depth != 0 SHALL go to ERROR; prog_len = 0 SHALL go to DONE; otherwise CLEAR.
REQ-024 CLEAR SHALL assert mem_clr_wr_en for exactly 2^MEM_ADDR_WIDTH consecutive cycles with mem_clr_addr 0,1,...,max, then go to RUN.
REQ-025 RUN SHALL drive core_rst low; when core_pc == prog_len (registered compare), SHALL go to DONE and core_rst SHALL be high the following cycle.
REQ-026 busy SHALL be high in LOAD, CLEAR and RUN; done SHALL be high only in DONE; err SHALL be high only in ERROR.
REQ-027 abort SHALL have priority over all other events, go to IDLE next cycle, and force prog_wr_en and mem_clr_wr_en low that cycle.
REQ-028 rx_valid outside LOAD SHALL NOT be acked.
REQ-029 A terminator on the same cycle as an overflow or bracket error SHALL resolve as ERROR.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, core_rst=1, and all other outputs, prog_len, depth and counters to 0, including mid-LOAD/CLEAR/RUN.
REQ-031 After rst_n rises, the block SHALL stay in IDLE until start.

Verification
REQ-032 Stream "+[-]." then 0x00 -> five prog writes at addresses 0..4, 256 clear cycles, RUN, DONE when core_pc=5.
REQ-033 Stream "a+ b\n" then 0x00 -> one write (I_PLUS at address 0), prog_len=1, all six bytes acked.
REQ-034 Stream "]" -> ERROR, err=1, no prog write; then start -> LOAD with prog_len=0.
REQ-035 Stream "[[]" then 0x00 -> three writes, then ERROR because depth=1.
REQ-036 Assert abort on the 100th CLEAR cycle -> IDLE next cycle, mem_clr_wr_en low, core_rst=1.
REQ-037 Drop rst_n mid-RUN -> core_rst=1 and debug_state=0 with no clock edge required.
